// File: rtl/dw_bscan_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state TMS decoder, instruction register, BYPASS/IDCODE
// data registers and the control strobes for a chain of BC_7/BC_2 boundary-scan cells.
module dw_bscan_tap_ctrl #(
  parameter int unsigned          IR_WIDTH   = 4,
  parameter logic [31:0]          IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0]  OP_EXTEST  = IR_WIDTH'(0),
  parameter logic [IR_WIDTH-1:0]  OP_SAMPLE  = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0]  OP_INTEST  = IR_WIDTH'(2),
  parameter logic [IR_WIDTH-1:0]  OP_IDCODE  = IR_WIDTH'(3)
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic                tms,
  input  logic                tdi,
  input  logic                bsr_so,
  output logic                shift_dr,
  output logic                capture_en,
  output logic                update_en,
  output logic                mode1,
  output logic                mode2,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] instr
);

  typedef enum logic [3:0] {
    TLR = 4'hF, RTI = 4'hC, SDS = 4'h7, CDR = 4'h6,
    SDR = 4'h2, E1D = 4'h1, PDR = 4'h3, E2D = 4'h0,
    UDR = 4'h5, SIS = 4'h4, CIR = 4'hE, SIR = 4'hA,
    E1I = 4'h9, PIR = 4'hB, E2I = 4'h8, UIR = 4'hD
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic                bypass_q, bypass_d;
  logic [31:0]         idcode_q, idcode_d;
  logic                shift_dr_q, shift_dr_d;
  logic                capture_en_q, capture_en_d;
  logic                update_en_q, update_en_d;
  logic                mode1_q, mode1_d;
  logic                mode2_q, mode2_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                bsr_sel, bsr_sel_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR: state_d = tms ? TLR : RTI;
      RTI: state_d = tms ? SDS : RTI;
      SDS: state_d = tms ? SIS : CDR;
      SIS: state_d = tms ? TLR : CIR;
      CDR: state_d = tms ? E1D : SDR;
      SDR: state_d = tms ? E1D : SDR;
      E1D: state_d = tms ? UDR : PDR;
      PDR: state_d = tms ? E2D : PDR;
      E2D: state_d = tms ? UDR : SDR;
      UDR: state_d = tms ? SDS : RTI;
      CIR: state_d = tms ? E1I : SIR;
      SIR: state_d = tms ? E1I : SIR;
      E1I: state_d = tms ? UIR : PIR;
      PIR: state_d = tms ? E2I : PIR;
      E2I: state_d = tms ? UIR : SIR;
      UIR: state_d = tms ? SDS : RTI;
    endcase
  end

  // NOTE: every variable gets its hold value first so no path through this block
  // leaves it unassigned -- that is what keeps it from becoming a latch.
  always_comb begin
    ir_shift_d = ir_shift_q;
    instr_d    = instr_q;
    bypass_d   = bypass_q;
    idcode_d   = idcode_q;
    case (state_q)
      CIR: ir_shift_d = IR_CAPTURE;
      SIR: ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
      UIR: instr_d    = ir_shift_q;
      CDR: begin
        bypass_d = 1'b0;
        idcode_d = IDCODE_VAL;
      end
      SDR: begin
        bypass_d = tdi;
        idcode_d = {tdi, idcode_q[31:1]};
      end
      default: ;
    endcase
    if (state_d == TLR) instr_d = OP_IDCODE;
  end

  // Controls are computed from the next state so the registered copies line up
  // with the state they belong to (Moore behaviour without combinational glitches).
  always_comb begin
    bsr_sel_d    = (instr_d == OP_EXTEST) || (instr_d == OP_SAMPLE) || (instr_d == OP_INTEST);
    shift_dr_d   = (state_d == SDR);
    capture_en_d = ~(bsr_sel_d && ((state_d == CDR) || (state_d == SDR)));
    update_en_d  = bsr_sel_d && (state_d == UDR);
    mode1_d      = (instr_d == OP_EXTEST) || (instr_d == OP_INTEST);
    mode2_d      = (instr_d == OP_INTEST);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values of each other, independent of block ordering.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q      <= TLR;
      ir_shift_q   <= IR_CAPTURE;
      instr_q      <= OP_IDCODE;
      bypass_q     <= 1'b0;
      idcode_q     <= IDCODE_VAL;
      shift_dr_q   <= 1'b0;
      capture_en_q <= 1'b1;
      update_en_q  <= 1'b0;
      mode1_q      <= 1'b0;
      mode2_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_shift_q   <= ir_shift_d;
      instr_q      <= instr_d;
      bypass_q     <= bypass_d;
      idcode_q     <= idcode_d;
      shift_dr_q   <= shift_dr_d;
      capture_en_q <= capture_en_d;
      update_en_q  <= update_en_d;
      mode1_q      <= mode1_d;
      mode2_q      <= mode2_d;
    end
  end

  assign bsr_sel = (instr_q == OP_EXTEST) || (instr_q == OP_SAMPLE) || (instr_q == OP_INTEST);

  always_comb begin
    tdo_d    = tdo_q;
    tdo_en_d = 1'b0;
    case (state_q)
      SIR: begin
        tdo_d    = ir_shift_q[0];
        tdo_en_d = 1'b1;
      end
      SDR: begin
        tdo_en_d = 1'b1;
        if (bsr_sel)                    tdo_d = bsr_so;
        else if (instr_q == OP_IDCODE)  tdo_d = idcode_q[0];
        else                            tdo_d = bypass_q;
      end
      TLR:     tdo_d = 1'b0;
      default: ;
    endcase
  end

  // tdo launches on the falling edge so the bit is stable around the next rising edge.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tap_state  = state_q;
  assign instr      = instr_q;
  assign shift_dr   = shift_dr_q;
  assign capture_en = capture_en_q;
  assign update_en  = update_en_q;
  assign mode1      = mode1_q;
  assign mode2      = mode2_q;
  assign tdo        = tdo_q;
  assign tdo_en     = tdo_en_q;

endmodule
